// File: rtl/ps2_pkg.sv
// Shared types and frame constants for the PS/2 keyboard receiver.
// No logic of its own; imported by the deframer.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;
  localparam int   CNT_W     = $clog2(DATA_BITS);

  // PS/2 uses odd parity across the data byte plus the parity bit.
  function automatic logic parity_ok(input logic [DATA_BITS-1:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Generic first-word-fall-through FIFO; rdata shows the head with zero read latency.
// A push while full is dropped unless a pop happens in the same cycle; a pop while empty is ignored.
module ps2_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // When full, the slot being written is the head being popped this cycle.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host receiver: sync, deframe, parity/stop check, timeout abort, FWFT byte buffer.
// A good byte is readable 4 CLOCK cycles after the stop-bit pin fall; bytes arriving while full are dropped with OVERFLOW.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 25000
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] DATA,
  output logic       READY,
  input  logic       RD,
  output logic       PERR,
  output logic       OVERFLOW
);

  localparam int TW = $clog2(TIMEOUT);

  logic [1:0]           clk_sync;
  logic [1:0]           dat_sync;
  logic                 clk_prev;
  logic                 fall;
  logic                 dat;
  ps2_state_t           state;
  logic [DATA_BITS-1:0] shift;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 par_bit;
  logic [TW-1:0]        to_cnt;
  logic                 timed_out;
  logic                 push;
  logic [DATA_BITS-1:0] push_dat;
  logic [7:0]           fifo_rdata;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 pop;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], PS2_CLK};
      dat_sync <= {dat_sync[0], PS2_DAT};
      clk_prev <= clk_sync[1];
    end
  end

  assign fall      = clk_prev & ~clk_sync[1];
  assign dat       = dat_sync[1];
  // A fall in the same cycle wins over the abort: the device is still clocking.
  assign timed_out = (state != ST_IDLE) && (to_cnt == TW'(TIMEOUT - 1)) && !fall;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state    <= ST_IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      par_bit  <= 1'b0;
      to_cnt   <= '0;
      push     <= 1'b0;
      push_dat <= '0;
      PERR     <= 1'b0;
    end else begin
      push <= 1'b0;
      PERR <= 1'b0;

      if (state == ST_IDLE || fall)          to_cnt <= '0;
      else if (to_cnt != TW'(TIMEOUT - 1))   to_cnt <= to_cnt + 1'b1;

      if (timed_out) begin
        state <= ST_IDLE;
        PERR  <= 1'b1;
      end else if (fall) begin
        case (state)
          ST_IDLE: begin
            if (dat == START_BIT) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            shift   <= {dat, shift[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == CNT_W'(DATA_BITS - 1)) state <= ST_PARITY;
          end
          ST_PARITY: begin
            par_bit <= dat;
            state   <= ST_STOP;
          end
          ST_STOP: begin
            if (dat == STOP_BIT && parity_ok(shift, par_bit)) begin
              push     <= 1'b1;
              push_dat <= shift;
            end else begin
              PERR <= 1'b1;
            end
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  ps2_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLOCK),
    .rst   (RESET),
    .push  (push),
    .wdata (push_dat),
    .pop   (pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign READY    = ~fifo_empty;
  assign pop      = RD & READY;
  assign DATA     = READY ? fifo_rdata : 8'h00;
  assign OVERFLOW = push & fifo_full & ~pop;

endmodule
